// File: rtl/cmul_pkg.sv
// Shared types and constants for the sequential 4-bit signed complex multiplier.
package cmul_pkg;

    localparam int CMUL_W = 4;
    localparam int PROD_W = 2 * CMUL_W;
    localparam int RES_W  = 9;

    typedef logic signed [CMUL_W-1:0] cmul_op_t;
    typedef logic signed [PROD_W-1:0] cmul_prod_t;
    typedef logic signed [RES_W-1:0]  cmul_res_t;

    typedef enum logic [2:0] {
        IDLE,
        P0,
        P1,
        P2,
        P3
    } cmul_state_e;

endpackage

// File: rtl/cmul_mux2x4.sv
// 4-bit 2:1 operand mux feeding one input of the shared multiplier.
module cmul_mux2x4 (
    input  logic       sel_i,
    input  logic [3:0] d0_i,
    input  logic [3:0] d1_i,
    output logic [3:0] y_o
);

    assign y_o = sel_i ? d1_i : d0_i;

endmodule

// File: rtl/complex_mult_fsm.sv
// Control for complex_mult_seq: state register, mux selects, busy/done and
// the load strobes for the operand, accumulator and result registers.
module complex_mult_fsm
    import cmul_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic start_i,
    output logic op_ld_o,
    output logic sel_a_o,
    output logic sel_b_o,
    output logic acc_ld_o,
    output logic re_ld_o,
    output logic res_ld_o,
    output logic busy_o,
    output logic done_o
);

    cmul_state_e state_q;
    logic        busy_q;
    logic        done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q <= P0;
                        busy_q  <= 1'b1;
                    end
                end
                P0: state_q <= P1;
                P1: state_q <= P2;
                P2: state_q <= P3;
                P3: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // P0: re*re, P1: im*im, P2: re*im, P3: im*re
    always_comb begin
        sel_a_o = 1'b0;
        sel_b_o = 1'b0;
        unique case (state_q)
            P1: begin
                sel_a_o = 1'b1;
                sel_b_o = 1'b1;
            end
            P2: sel_b_o = 1'b1;
            P3: sel_a_o = 1'b1;
            default: ;
        endcase
    end

    assign op_ld_o  = (state_q == IDLE) && start_i;
    assign acc_ld_o = (state_q == P0) || (state_q == P2);
    assign re_ld_o  = (state_q == P1);
    assign res_ld_o = (state_q == P3);
    assign busy_o   = busy_q;
    assign done_o   = done_q;

endmodule

// File: rtl/complex_mult_seq.sv
// Sequential 4-bit signed complex multiplier: one shared multiplier, one accumulator,
// four compute cycles. Define CMUL_SAT_EN to clamp results to the 8-bit signed range.
module complex_mult_seq
    import cmul_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] a_re,
    input  logic [3:0] a_im,
    input  logic [3:0] b_re,
    input  logic [3:0] b_im,
    output logic [8:0] re,
    output logic [8:0] im,
    output logic       busy,
    output logic       done
);

    logic       op_ld, sel_a, sel_b, acc_ld, re_ld, res_ld;
    logic [3:0] a_re_q, a_im_q, b_re_q, b_im_q;
    logic [3:0] mul_x, mul_y;
    cmul_op_t   mx, my;
    cmul_prod_t prod;
    cmul_res_t  prod_ext, acc_q, re_nxt_q, re_q, im_q;
    cmul_res_t  diff, sum, re_res, im_res;

`ifdef CMUL_SAT_EN
    function automatic cmul_res_t sat8(input cmul_res_t v);
        if (v > 9'sh07F)
            return 9'sh07F;
        else if (v < 9'sh180)
            return 9'sh180;
        return v;
    endfunction
`endif

    complex_mult_fsm u_fsm (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start),
        .op_ld_o  (op_ld),
        .sel_a_o  (sel_a),
        .sel_b_o  (sel_b),
        .acc_ld_o (acc_ld),
        .re_ld_o  (re_ld),
        .res_ld_o (res_ld),
        .busy_o   (busy),
        .done_o   (done)
    );

    cmul_mux2x4 u_mux_a (.sel_i(sel_a), .d0_i(a_re_q), .d1_i(a_im_q), .y_o(mul_x));
    cmul_mux2x4 u_mux_b (.sel_i(sel_b), .d0_i(b_re_q), .d1_i(b_im_q), .y_o(mul_y));

    // Both operands sign-extended to 8 bits; the 8-bit product cannot overflow (range -56..64).
    assign mx       = mul_x;
    assign my       = mul_y;
    assign prod     = $signed({{CMUL_W{mx[CMUL_W-1]}}, mx}) * $signed({{CMUL_W{my[CMUL_W-1]}}, my});
    assign prod_ext = {prod[PROD_W-1], prod};
    assign diff     = acc_q - prod_ext;
    assign sum      = acc_q + prod_ext;

`ifdef CMUL_SAT_EN
    assign re_res = sat8(re_nxt_q);
    assign im_res = sat8(sum);
`else
    assign re_res = re_nxt_q;
    assign im_res = sum;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_re_q   <= '0;
            a_im_q   <= '0;
            b_re_q   <= '0;
            b_im_q   <= '0;
            acc_q    <= '0;
            re_nxt_q <= '0;
            re_q     <= '0;
            im_q     <= '0;
        end else begin
            if (op_ld) begin
                a_re_q <= a_re;
                a_im_q <= a_im;
                b_re_q <= b_re;
                b_im_q <= b_im;
            end
            if (acc_ld)
                acc_q <= prod_ext;
            if (re_ld)
                re_nxt_q <= diff;
            // re and im commit together so the outputs never show a half-updated result
            if (res_ld) begin
                re_q <= re_res;
                im_q <= im_res;
            end
        end
    end

    assign re = re_q;
    assign im = im_q;

endmodule

// File: tb/tb_complex_mult_seq.sv
// Directed self-checking bench for complex_mult_seq (expects CMUL_SAT_EN-aware results).
module tb_complex_mult_seq;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [3:0]        a_re, a_im, b_re, b_im;
    logic signed [8:0] re, im;
    logic              busy, done;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    complex_mult_seq dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a_re  (a_re),
        .a_im  (a_im),
        .b_re  (b_re),
        .b_im  (b_im),
        .re    (re),
        .im    (im),
        .busy  (busy),
        .done  (done)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int ar, input int ai, input int br, input int bi);
        a_re = 4'(ar);
        a_im = 4'(ai);
        b_re = 4'(br);
        b_im = 4'(bi);
    endtask

    // Advance at least one edge, then until done is seen or the budget runs out.
    task automatic wait_next(input int max, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!done && n < max);
    endtask

    // One complete transaction with a single-cycle start pulse.
    task automatic op_check(input string tag, input int ar, input int ai, input int br,
                            input int bi, input int exp_re, input int exp_im);
        int busy_cnt;
        busy_cnt = 0;
        set_ops(ar, ai, br, bi);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (busy) busy_cnt++;
            check({tag, "_nodone_while_busy"}, int'(done), 0);
            tick();
        end
        check({tag, "_busy_cycles"}, busy_cnt, 4);
        check({tag, "_done"}, int'(done), 1);
        check({tag, "_busy_at_done"}, int'(busy), 0);
        check({tag, "_re"}, int'(re), exp_re);
        check({tag, "_im"}, int'(im), exp_im);
        tick();
        check({tag, "_done_pulse"}, int'(done), 0);
    endtask

    initial begin
        int n;
        int dcnt;
        int got_re, got_im;
        int exp_im_ext;

`ifdef CMUL_SAT_EN
        exp_im_ext = 127;
`else
        exp_im_ext = 128;
`endif

        rst   = 1'b1;
        start = 1'b0;
        set_ops(0, 0, 0, 0);
        tick();
        tick();
        check("rst_re", int'(re), 0);
        check("rst_im", int'(im), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        rst = 1'b0;
        tick();
        check("post_rst_busy", int'(busy), 0);
        check("post_rst_done", int'(done), 0);

        // (1+2j)(3+4j) = -5+10j
        op_check("basic", 1, 2, 3, 4, -5, 10);

        // (-8-8j)^2 = 0+128j
        op_check("extreme", -8, -8, -8, -8, 0, exp_im_ext);

        // (2-3j)(-1+5j) = 13+13j, inputs disturbed during P1
        set_ops(2, -3, -1, 5);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        set_ops(7, 7, 7, 7);
        wait_next(10, n);
        check("stable_latency", n, 3);
        check("stable_done", int'(done), 1);
        check("stable_re", int'(re), 13);
        check("stable_im", int'(im), 13);
        tick();

        // (3+1j)(2-1j) = 7-1j, with a stray start during P2
        set_ops(3, 1, 2, -1);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        dcnt   = 0;
        got_re = 0;
        got_im = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done) begin
                dcnt++;
                got_re = int'(re);
                got_im = int'(im);
            end
        end
        check("busy_start_dones", dcnt, 1);
        check("busy_start_re", got_re, 7);
        check("busy_start_im", got_im, -1);
        // (-2+3j)(4+0j) = -8+12j
        op_check("after_ignored", -2, 3, 4, 0, -8, 12);

        // start held high: (1+1j)^2 = 2j, then (7)(-8) = -56
        set_ops(1, 1, 1, 1);
        start = 1'b1;
        tick();
        set_ops(7, 0, -8, 0);
        wait_next(10, n);
        check("b2b_first_latency", n, 4);
        check("b2b_first_re", int'(re), 0);
        check("b2b_first_im", int'(im), 2);
        wait_next(10, n);
        check("b2b_spacing", n, 5);
        check("b2b_second_re", int'(re), -56);
        check("b2b_second_im", int'(im), 0);
        tick();
        tick();
        start = 1'b0;
        wait_next(10, n);
        check("b2b_third_latency", n, 3);
        check("b2b_third_done", int'(done), 1);
        check("b2b_third_re", int'(re), -56);
        tick();
        check("b2b_idle_after", int'(busy), 0);

        // reset asserted in P1 aborts the operation
        set_ops(1, 2, 3, 4);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        check("abort_re", int'(re), 0);
        check("abort_im", int'(im), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        #1;
        rst = 1'b0;
        dcnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done) dcnt++;
        end
        check("abort_no_done", dcnt, 0);
        op_check("after_abort", 1, 2, 3, 4, -5, 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
